// File: rtl/mtsp_trd_scheduler.sv
// mtsp_trd_scheduler: round-robin fetch thread scheduler for the MTSP core.
// It picks one runnable, unlocked thread per cycle and drives it into fetch as
// an active-low one-hot select. It holds an unconsumed grant until fetch takes
// it. After a grant, the granted thread is locked out for LOCK_CYCLES cycles.
//
// Optional feature: define MTSP_SCHED_PRIORITY_EN to add PRI_TRD. The
// round-robin search then prefers PRI_TRD threads and shares one pointer with
// the normal search.
//
// Ports:
//   CLK        main clock
//   RST        synchronous reset, active-high
//   TRD_RUN    per-thread runnable flag
//   KILL_nTRD  active-low per-thread lockout clear
//   IF_READY   fetch accepts the current selection this cycle
//   PRI_TRD    high-priority thread mask (MTSP_SCHED_PRIORITY_EN only)
//   IF_nEN     registered one-hot active-low thread select, all ones when none
//   IF_VALID   registered, IF_nEN holds a valid grant
//   SCHED_IDLE registered, no thread was eligible in the previous cycle
module mtsp_trd_scheduler #(
    parameter int unsigned TRD_COUNT   = 12,
    parameter int unsigned LOCK_CYCLES = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [TRD_COUNT-1:0] TRD_RUN,
    input  logic [TRD_COUNT-1:0] KILL_nTRD,
    input  logic                 IF_READY,
`ifdef MTSP_SCHED_PRIORITY_EN
    input  logic [TRD_COUNT-1:0] PRI_TRD,
`endif
    output logic [TRD_COUNT-1:0] IF_nEN,
    output logic                 IF_VALID,
    output logic                 SCHED_IDLE
);

    localparam int unsigned LW = (LOCK_CYCLES == 0) ? 1 : $clog2(LOCK_CYCLES + 1);
    localparam int unsigned PW = $clog2(TRD_COUNT);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYCLES);

    logic [LW-1:0]          lock_q [TRD_COUNT];
    logic [PW-1:0]          ptr_q;
    logic [TRD_COUNT-1:0]   eligible_c;
    logic [TRD_COUNT-1:0]   search_c;
    logic [2*TRD_COUNT-1:0] dbl_c;
    logic [TRD_COUNT-1:0]   rot_c;
    logic [PW-1:0]          start_c;
    logic [PW-1:0]          off_c;
    logic [PW:0]            sum_c;
    logic [PW-1:0]          grant_c;
    logic                   found_c;
    logic                   issue_c;

    // A thread is eligible when it is runnable and its lockout has expired.
    always_comb begin
        eligible_c = '0;
        for (int i = 0; i < TRD_COUNT; i++) begin
            eligible_c[i] = TRD_RUN[i] & (lock_q[i] == '0);
        end
    end

    // The priority subset wins whenever it is non-empty.
`ifdef MTSP_SCHED_PRIORITY_EN
    always_comb search_c = (|(eligible_c & PRI_TRD)) ? (eligible_c & PRI_TRD) : eligible_c;
`else
    always_comb search_c = eligible_c;
`endif

    // Rotate the candidate set so that bit 0 is the thread after the last grant.
    // The lowest set bit is then the round-robin winner.
    always_comb begin
        start_c = (ptr_q == PW'(TRD_COUNT - 1)) ? '0 : ptr_q + PW'(1);
        dbl_c   = {search_c, search_c};
        rot_c   = TRD_COUNT'(dbl_c >> start_c);
        found_c = 1'b0;
        off_c   = '0;
        for (int j = TRD_COUNT - 1; j >= 0; j--) begin
            if (rot_c[j]) begin
                found_c = 1'b1;
                off_c   = PW'(j);
            end
        end
        sum_c   = {1'b0, start_c} + {1'b0, off_c};
        grant_c = (sum_c >= (PW+1)'(TRD_COUNT)) ? PW'(sum_c - (PW+1)'(TRD_COUNT)) : PW'(sum_c);
    end

    // The current grant is consumed, or there is none to hold.
    always_comb issue_c = ~IF_VALID | IF_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            IF_nEN     <= '1;
            IF_VALID   <= 1'b0;
            SCHED_IDLE <= 1'b1;
            ptr_q      <= PW'(TRD_COUNT - 1);
            for (int i = 0; i < TRD_COUNT; i++) begin
                lock_q[i] <= '0;
            end
        end else begin
            SCHED_IDLE <= ~|eligible_c;
            if (issue_c) begin
                if (found_c) begin
                    IF_nEN   <= ~(TRD_COUNT'(1) << grant_c);
                    IF_VALID <= 1'b1;
                    ptr_q    <= grant_c;
                end else begin
                    IF_nEN   <= '1;
                    IF_VALID <= 1'b0;
                end
            end
            // A lock load on grant beats a kill, and a kill beats the countdown.
            for (int i = 0; i < TRD_COUNT; i++) begin
                if (issue_c && found_c && (grant_c == PW'(i))) begin
                    lock_q[i] <= LOCK_LOAD;
                end else if (!KILL_nTRD[i]) begin
                    lock_q[i] <= '0;
                end else if (lock_q[i] != '0) begin
                    lock_q[i] <= lock_q[i] - LW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mtsp_trd_scheduler.sv
// Self-checking bench for mtsp_trd_scheduler. A behavioural model tracks
// per-thread lock countdowns, the last-grant pointer and the held grant. Every
// cycle the bench compares the DUT outputs against that model. Directed
// sequences pin the model with literal expectations. A long randomized run
// follows.
module tb_mtsp_trd_scheduler;

`ifdef MTSP_SCHED_PRIORITY_EN
    localparam int TB_LOCK = 0;
`else
    localparam int TB_LOCK = 4;
`endif
    localparam int N = 12;

    logic        clk;
    logic        rst;
    logic [11:0] run;
    logic [11:0] kill_n;
    logic        ready;
    logic [11:0] pri;
    logic [11:0] if_nen;
    logic        if_valid;
    logic        sched_idle;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    int m_lock [N];
    int m_ptr;
    bit m_valid;
    int m_g;
    bit m_idle;

    mtsp_trd_scheduler #(.TRD_COUNT(N), .LOCK_CYCLES(TB_LOCK)) dut (
        .CLK       (clk),
        .RST       (rst),
        .TRD_RUN   (run),
        .KILL_nTRD (kill_n),
        .IF_READY  (ready),
`ifdef MTSP_SCHED_PRIORITY_EN
        .PRI_TRD   (pri),
`endif
        .IF_nEN    (if_nen),
        .IF_VALID  (if_valid),
        .SCHED_IDLE(sched_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        bit el [N];
        bit any;
        int g;
        bit hold;
        if (rst) begin
            for (int i = 0; i < N; i++) m_lock[i] = 0;
            m_ptr = N - 1; m_valid = 0; m_g = 0; m_idle = 1;
        end else begin
            any = 0;
            g = -1;
            hold = m_valid && !ready;
            for (int i = 0; i < N; i++) begin
                el[i] = run[i] && (m_lock[i] == 0);
                any |= el[i];
            end
            if (!hold) begin
`ifdef MTSP_SCHED_PRIORITY_EN
                for (int k = 1; k <= N; k++)
                    if (g < 0 && el[(m_ptr + k) % N] && pri[(m_ptr + k) % N]) g = (m_ptr + k) % N;
`endif
                for (int k = 1; k <= N; k++)
                    if (g < 0 && el[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                if (g >= 0) begin
                    m_valid = 1; m_g = g; m_ptr = g;
                end else begin
                    m_valid = 0;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (g == i) m_lock[i] = TB_LOCK;
                else if (!kill_n[i]) m_lock[i] = 0;
                else if (m_lock[i] > 0) m_lock[i] = m_lock[i] - 1;
            end
            m_idle = !any;
        end
    endtask

    // One clock: model update, edge, then compare all outputs against the model.
    task automatic step();
        logic [11:0] one;
        logic [11:0] exp_nen;
        one = 12'h001;
        model_step();
        @(posedge clk);
        #1;
        exp_nen = m_valid ? ~(one << m_g) : 12'hFFF;
        chk("model_nen", if_nen, exp_nen);
        chk("model_valid", {11'b0, if_valid}, {11'b0, m_valid});
        chk("model_idle", {11'b0, sched_idle}, {11'b0, m_idle});
    endtask

    task automatic do_reset();
        rst = 1'b1; run = '0; kill_n = 12'hFFF; ready = 1'b0; pri = '0;
        step();
        chk("rst_nen", if_nen, 12'hFFF);
        chk("rst_valid", {11'b0, if_valid}, 12'h000);
        chk("rst_idle", {11'b0, sched_idle}, 12'h001);
        rst = 1'b0;
    endtask

    initial begin
        logic [11:0] one;
        one = 12'h001;
        rst = 1'b1; run = '0; kill_n = 12'hFFF; ready = 1'b0; pri = '0;
        @(negedge clk);
        do_reset();

`ifdef MTSP_SCHED_PRIORITY_EN
        // Priority threads 4 and 5 alternate, then round-robin resumes after 5.
        run = 12'hFFF; ready = 1'b1; pri = 12'h030;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("pri_alt", if_nen, (k % 2 == 0) ? 12'hFEF : 12'hFDF);
        end
        pri = 12'h000;
        step();
        chk("pri_resume", if_nen, 12'hFBF);
`else
        // All threads runnable: grants walk 0..11 and wrap with no gaps.
        run = 12'hFFF; ready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            step();
            chk("rr_nen", if_nen, ~(one << (k % 12)));
            chk("rr_valid", {11'b0, if_valid}, 12'h001);
        end

        // One runnable thread: one grant every LOCK_CYCLES+1 cycles.
        do_reset();
        run = 12'h001; ready = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            chk("single_nen", if_nen, (c % 5 == 1) ? 12'hFFE : 12'hFFF);
            chk("single_valid", {11'b0, if_valid}, (c % 5 == 1) ? 12'h001 : 12'h000);
        end

        // A grant to thread 3 is held through stall, then thread 4 follows.
        do_reset();
        run = 12'hFFF; ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        chk("hold_pre", if_nen, 12'hFF7);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold_nen", if_nen, 12'hFF7);
        end
        ready = 1'b1;
        step();
        chk("hold_next", if_nen, 12'hFEF);

        // A kill clears thread 0's lockout so it is re-granted early.
        do_reset();
        run = 12'h001; ready = 1'b1;
        step();
        chk("kill_first", if_nen, 12'hFFE);
        kill_n = 12'hFFE;
        step();
        chk("kill_gap", if_nen, 12'hFFF);
        kill_n = 12'hFFF;
        step();
        chk("kill_regrant", if_nen, 12'hFFE);

        // Idle with nothing runnable, then thread 7 is granted a cycle later.
        do_reset();
        run = 12'h000; ready = 1'b1;
        step();
        chk("idle_flag", {11'b0, sched_idle}, 12'h001);
        chk("idle_valid", {11'b0, if_valid}, 12'h000);
        run = 12'h080;
        step();
        chk("wake_nen", if_nen, 12'hF7F);
        chk("wake_idle", {11'b0, sched_idle}, 12'h000);
`endif

        // Randomized traffic with stalls, kills and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst    = ($urandom_range(0, 199) == 0);
            run    = ($urandom_range(0, 3) == 0) ? 12'($urandom)
                                                  : 12'($urandom) & 12'($urandom) & 12'($urandom);
            ready  = ($urandom_range(0, 3) != 0);
            kill_n = ~(12'($urandom) & 12'($urandom) & 12'($urandom));
            pri    = 12'($urandom) & 12'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
